// File: rtl/systolic_2x2_stream_feeder.sv
// Stream front/back end for the 2x2 systolic matrix-multiply array.
// Packs eight serial elements (A row-major, then B row-major) into the array's
// mi0/mi1 buses. It waits LAT edges for the array's registered result, then
// streams C = A*B back out in row-major order through a ready/valid handshake.
module systolic_2x2_stream_feeder #(
   parameter int SIZE    = 8,
   parameter int DECIMAL = 4,
   parameter int LAT     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SIZE-1:0]     in_data_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic [4*SIZE-1:0]   mi0_o,
   output logic [4*SIZE-1:0]   mi1_o,
   input  logic [4*SIZE-1:0]   mor_i,
   output logic [SIZE-1:0]     out_data_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                busy_o,
   output logic                frame_done_o
);

   localparam int LW = $clog2(LAT + 1);

   typedef enum logic [1:0] {LOAD, WAIT, DRAIN} state_t;

   // DECIMAL only describes the array's number format; the feeder never does
   // arithmetic, so it is checked for sanity here and otherwise unused.
   if (LAT < 2 || DECIMAL >= SIZE) begin : gBadParams
      $error("systolic_2x2_stream_feeder: needs LAT >= 2 and DECIMAL < SIZE");
   end

   state_t              state_q;
   logic [2:0]          cnt_q;
   logic [LW-1:0]       latCnt_q;
   logic [4*SIZE-1:0]   mi0_q;
   logic [4*SIZE-1:0]   mi1_q;
   logic [4*SIZE-1:0]   res_q;
   logic [SIZE-1:0]     outData_q;
   logic                outValid_q;
   logic                busy_q;
   logic                frameDone_q;

   // Field idx 0..3 maps to X00, X01, X10, X11 (X00 in the top bits).
   function automatic logic [SIZE-1:0] fieldOf(input logic [4*SIZE-1:0] vec,
                                               input logic [1:0] idx);
      logic [SIZE-1:0] f;
      case (idx)
         2'd0:    f = vec[4*SIZE-1 -: SIZE];
         2'd1:    f = vec[3*SIZE-1 -: SIZE];
         2'd2:    f = vec[2*SIZE-1 -: SIZE];
         default: f = vec[SIZE-1 -: SIZE];
      endcase
      return f;
   endfunction

   // Replace one field of a packed matrix and leave the other three untouched.
   function automatic logic [4*SIZE-1:0] putField(input logic [4*SIZE-1:0] vec,
                                                  input logic [1:0] idx,
                                                  input logic [SIZE-1:0] data);
      logic [4*SIZE-1:0] v;
      v = vec;
      case (idx)
         2'd0:    v[4*SIZE-1 -: SIZE] = data;
         2'd1:    v[3*SIZE-1 -: SIZE] = data;
         2'd2:    v[2*SIZE-1 -: SIZE] = data;
         default: v[SIZE-1 -: SIZE]   = data;
      endcase
      return v;
   endfunction

   // Frame sequencer: load eight elements, wait out the array latency, drain four results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= LOAD;
         cnt_q       <= 3'd0;
         latCnt_q    <= '0;
         mi0_q       <= '0;
         mi1_q       <= '0;
         res_q       <= '0;
         outData_q   <= '0;
         outValid_q  <= 1'b0;
         busy_q      <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         frameDone_q <= 1'b0;
         case (state_q)
            LOAD: begin
               if (in_valid_i) begin
                  if (!cnt_q[2]) begin
                     mi0_q <= putField(mi0_q, cnt_q[1:0], in_data_i);
                  end else begin
                     mi1_q <= putField(mi1_q, cnt_q[1:0], in_data_i);
                  end
                  if (cnt_q == 3'd7) begin
                     state_q  <= WAIT;
                     cnt_q    <= 3'd0;
                     latCnt_q <= '0;
                     busy_q   <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end
            WAIT: begin
               if (latCnt_q == LW'(LAT - 1)) begin
                  res_q      <= mor_i;
                  outData_q  <= fieldOf(mor_i, 2'd0);
                  outValid_q <= 1'b1;
                  cnt_q      <= 3'd0;
                  state_q    <= DRAIN;
               end else begin
                  latCnt_q <= latCnt_q + LW'(1);
               end
            end
            DRAIN: begin
               if (out_ready_i) begin
                  if (cnt_q[1:0] == 2'd3) begin
                     state_q     <= LOAD;
                     cnt_q       <= 3'd0;
                     outValid_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     frameDone_q <= 1'b1;
                  end else begin
                     cnt_q     <= cnt_q + 3'd1;
                     outData_q <= fieldOf(res_q, cnt_q[1:0] + 2'd1);
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   // Ready follows the state but is forced low while reset is held.
   assign in_ready_o   = rst & (state_q == LOAD);
   assign mi0_o        = mi0_q;
   assign mi1_o        = mi1_q;
   assign out_data_o   = outData_q;
   assign out_valid_o  = outValid_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_systolic_2x2_stream_feeder.sv
// Testbench for systolic_2x2_stream_feeder with a behavioural 2x2 fixed-point
// array (Q4.4, one register stage) closing the loop from mi0/mi1 back to mor.
module tb_systolic_2x2_stream_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] mi0;
   logic [31:0] mi1;
   logic [31:0] mor;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        frame_done;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      bit          randMode;
   } frameVec_t;

   frameVec_t tbl[5];

   systolic_2x2_stream_feeder #(.SIZE(8), .DECIMAL(4), .LAT(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .mi0_o       (mi0),
      .mi1_o       (mi1),
      .mor_i       (mor),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .busy_o      (busy),
      .frame_done_o(frame_done)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // One dot-product term of the array in Q4.4: (a0*b0 + a1*b1) >> 4, truncated.
   function automatic logic [7:0] fx(input logic [7:0] a0, input logic [7:0] b0,
                                     input logic [7:0] a1, input logic [7:0] b1);
      logic signed [15:0] p0;
      logic signed [15:0] p1;
      logic [16:0]        s;
      p0 = $signed(a0) * $signed(b0);
      p1 = $signed(a1) * $signed(b1);
      s  = {p0[15], p0} + {p1[15], p1};
      return s[11:4];
   endfunction

   // Array stand-in: registers C = A*B one edge after mi0/mi1 change.
   always @(posedge clk) begin
      mor <= {fx(mi0[31:24], mi1[31:24], mi0[23:16], mi1[15:8]),
              fx(mi0[31:24], mi1[23:16], mi0[23:16], mi1[7:0]),
              fx(mi0[15:8],  mi1[31:24], mi0[7:0],   mi1[15:8]),
              fx(mi0[15:8],  mi1[23:16], mi0[7:0],   mi1[7:0])};
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      fails++;
      $display("[TB] FAIL %s: timed out waiting for handshake", name);
   endtask

   // Drive elements first..last of a frame, optionally idling every other cycle.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input int first, input int last, input bit toggle);
      logic [7:0] d;
      bit         done;
      bit         phase;
      int         guard;
      phase = 1'b0;
      for (int k = first; k <= last; k++) begin
         d     = (k < 4) ? a[31-8*k -: 8] : b[31-8*(k-4) -: 8];
         done  = 1'b0;
         guard = 0;
         while (!done) begin
            @(negedge clk);
            phase = ~phase;
            if (toggle && phase) begin
               in_valid = 1'b0;
            end else begin
               in_valid = 1'b1;
               in_data  = d;
               done     = in_ready;
            end
            guard++;
            if (guard > 50 && !done) begin
               reportTimeout("send_elem");
               done = 1'b1;
            end
            @(posedge clk);
         end
      end
      #1 in_valid = 1'b0;
   endtask

   // Collect four results, checking order, stall stability and the frame_done pulse.
   task automatic recvFrame(input logic [31:0] c, input bit randReady, output int latency);
      int         got;
      int         guard;
      int         lat;
      bit         seen;
      bit         stalled;
      logic [7:0] held;
      got = 0; guard = 0; lat = 0; seen = 1'b0; stalled = 1'b0; held = '0;
      while (got < 4 && guard < 200) begin
         @(negedge clk);
         guard++;
         out_ready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (stalled) checkOutput("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held});
         if (out_valid) begin
            seen = 1'b1;
            checkOutput("in_ready_drain", {31'd0, in_ready}, 32'd0);
            if (out_ready) begin
               checkOutput("out_elem", {24'd0, out_data}, {24'd0, c[31-8*got -: 8]});
               got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = out_data;
            end
         end else if (!seen) begin
            lat++;
            checkOutput("busy_wait", {31'd0, busy}, 32'd1);
         end
      end
      if (got < 4) reportTimeout("recv_frame");
      latency = lat;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("frame_done", {31'd0, frame_done}, 32'd1);
      checkOutput("busy_idle", {31'd0, busy}, 32'd0);
      checkOutput("in_ready_load", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("frame_done_pulse", {31'd0, frame_done}, 32'd0);
   endtask

   // Reset assertion checks every output immediately, release re-opens LOAD.
   task automatic pulseReset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("rst_mi0", mi0, 32'd0);
      checkOutput("rst_mi1", mi1, 32'd0);
      checkOutput("rst_out", {22'd0, out_valid, busy, out_data}, 32'd0);
      checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rel_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rel_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int lat;
      tbl[0] = '{a: 32'h10000010, b: 32'h10203040, c: 32'h10203040, randMode: 1'b0};
      tbl[1] = '{a: 32'h10000010, b: 32'h10203040, c: 32'h10203040, randMode: 1'b1};
      tbl[2] = '{a: 32'h10100010, b: 32'h10203040, c: 32'h40603040, randMode: 1'b0};
      tbl[3] = '{a: 32'hF0000010, b: 32'h10203040, c: 32'hF0E03040, randMode: 1'b1};
      tbl[4] = '{a: 32'h2010F000, b: 32'h10203040, c: 32'h5080F0E0, randMode: 1'b0};

      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      pulseReset();

      // Back-to-back frames from the table, checking the packed buses and results.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(tbl[i].a, tbl[i].b, 0, 7, tbl[i].randMode);
         checkOutput("mi0_loaded", mi0, tbl[i].a);
         checkOutput("mi1_loaded", mi1, tbl[i].b);
         recvFrame(tbl[i].c, tbl[i].randMode, lat);
         if (!tbl[i].randMode) checkOutput("latency", lat, 32'd2);
         checkOutput("mi0_hold", mi0, tbl[i].a);
      end

      // in_valid stays high through WAIT/DRAIN; only k=0 of the next frame loads after frame_done.
      applyStimulus(tbl[2].a, tbl[2].b, 0, 7, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h20;
      recvFrame(tbl[2].c, 1'b0, lat);
      checkOutput("hold_mi0", mi0, {8'h20, tbl[2].a[23:0]});
      checkOutput("hold_mi1", mi1, tbl[2].b);
      applyStimulus(32'h20000020, 32'h10000010, 1, 7, 1'b0);
      checkOutput("hold_next_mi0", mi0, 32'h20000020);
      recvFrame(32'h20000020, 1'b0, lat);

      // Reset after five elements discards the partial frame.
      applyStimulus(32'h11223344, 32'h55667788, 0, 4, 1'b0);
      pulseReset();
      applyStimulus(32'h20000020, 32'h10000010, 0, 7, 1'b0);
      checkOutput("post_rst_mi0", mi0, 32'h20000020);
      checkOutput("post_rst_mi1", mi1, 32'h10000010);
      recvFrame(32'h20000020, 1'b1, lat);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
